seven_stage_hazard_tracker: RTL

- Producer side of the seven-stage core's forwarding interface: tracks destination registers of in-flight instructions in execute, memory_issue, memory_receive and writeback.
- Compares them against the decode-stage sources and drives true_data_hazard and the per-stage rs1/rs2 hazard flags consumed by seven_stage_bypass_unit.
- On load-use hazards, holds decode and injects a bubble into execute.
- Sits in the seven-stage control path, between decode and seven_stage_bypass_unit.

---
 rtl/seven_stage_pkg.sv | 26 ++
 rtl/seven_stage_hazard_tracker_if.sv | 41 ++++
 rtl/seven_stage_hazard_match.sv | 48 ++++
 rtl/seven_stage_hazard_tracker.sv | 115 +++++++++++
 4 files changed

// File: rtl/seven_stage_pkg.sv
// Shared definitions for the seven-stage core's hazard tracking and bypass selection.
// Stage records are flat vectors so their width can follow the register address width.
package seven_stage_pkg;

    // Stage record layout: {rd, valid, regwrite, load}, with rd at the top.
    localparam int REC_LOAD     = 0;
    localparam int REC_REGWRITE = 1;
    localparam int REC_VALID    = 2;
    localparam int REC_RD_LSB   = 3;

    function automatic int rec_width(input int addr_width);
        return addr_width + REC_RD_LSB;
    endfunction

    // An empty stage; only the valid bit matters, the rest is cleared for tidiness.
    localparam logic [63:0] STAGE_BUBBLE = '0;

    typedef enum logic [2:0] {
        BYP_REGFILE        = 3'b000,
        BYP_EXECUTE        = 3'b001,
        BYP_MEMORY_ISSUE   = 3'b010,
        BYP_MEMORY_RECEIVE = 3'b011,
        BYP_WRITEBACK      = 3'b100
    } bypass_sel_e;

endpackage

// File: rtl/seven_stage_hazard_tracker_if.sv
// Decode-side view of the hazard tracker: decoded operands in, hazard and bypass flags out.
interface seven_stage_hazard_tracker_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      decode_valid;
    logic [REG_ADDR_WIDTH-1:0] decode_rs1;
    logic [REG_ADDR_WIDTH-1:0] decode_rs2;
    logic                      decode_rs1_used;
    logic                      decode_rs2_used;
    logic [REG_ADDR_WIDTH-1:0] decode_rd;
    logic                      decode_regwrite;
    logic                      decode_load;

    logic true_data_hazard;
    logic stall_decode;
    logic rs1_hazard_execute;
    logic rs1_hazard_memory_issue;
    logic rs1_hazard_memory_receive;
    logic rs1_hazard_writeback;
    logic rs2_hazard_execute;
    logic rs2_hazard_memory_issue;
    logic rs2_hazard_memory_receive;
    logic rs2_hazard_writeback;

    modport master (
        output decode_valid, decode_rs1, decode_rs2, decode_rs1_used, decode_rs2_used,
               decode_rd, decode_regwrite, decode_load,
        input  true_data_hazard, stall_decode,
               rs1_hazard_execute, rs1_hazard_memory_issue, rs1_hazard_memory_receive, rs1_hazard_writeback,
               rs2_hazard_execute, rs2_hazard_memory_issue, rs2_hazard_memory_receive, rs2_hazard_writeback
    );

    modport slave (
        input  decode_valid, decode_rs1, decode_rs2, decode_rs1_used, decode_rs2_used,
               decode_rd, decode_regwrite, decode_load,
        output true_data_hazard, stall_decode,
               rs1_hazard_execute, rs1_hazard_memory_issue, rs1_hazard_memory_receive, rs1_hazard_writeback,
               rs2_hazard_execute, rs2_hazard_memory_issue, rs2_hazard_memory_receive, rs2_hazard_writeback
    );

endinterface

// File: rtl/seven_stage_hazard_match.sv
// Priority compare of one decode source against the four in-flight stage records.
// Youngest producer wins; x0 is never produced.
module seven_stage_hazard_match
    import seven_stage_pkg::*;
#(
    parameter  int REG_ADDR_WIDTH = 5,
    localparam int REC_W          = rec_width(REG_ADDR_WIDTH)
) (
    input  logic                      src_used,
    input  logic [REG_ADDR_WIDTH-1:0] src,
    input  logic [REC_W-1:0]          ex_rec,
    input  logic [REC_W-1:0]          mi_rec,
    input  logic [REC_W-1:0]          mr_rec,
    input  logic [REC_W-1:0]          wb_rec,
    output logic [3:0]                stage_hit,    // {wb, mr, mi, ex}
    output logic                      load_pending
);

    function automatic logic produces(input logic [REC_W-1:0] rec, input logic [REG_ADDR_WIDTH-1:0] r);
        return rec[REC_VALID] && rec[REC_REGWRITE]
            && (rec[REC_RD_LSB +: REG_ADDR_WIDTH] == r) && (r != '0);
    endfunction

    bypass_sel_e sel;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sel          = BYP_REGFILE;
        load_pending = 1'b0;
        if (src_used) begin
            if (produces(ex_rec, src)) begin
                sel          = BYP_EXECUTE;
                load_pending = ex_rec[REC_LOAD];
            end else if (produces(mi_rec, src)) begin
                sel          = BYP_MEMORY_ISSUE;
                load_pending = mi_rec[REC_LOAD];
            end else if (produces(mr_rec, src)) begin
                sel = BYP_MEMORY_RECEIVE;
            end else if (produces(wb_rec, src)) begin
                sel = BYP_WRITEBACK;
            end
        end
    end

    assign stage_hit = {sel == BYP_WRITEBACK, sel == BYP_MEMORY_RECEIVE,
                        sel == BYP_MEMORY_ISSUE, sel == BYP_EXECUTE};

endmodule

// File: rtl/seven_stage_hazard_tracker.sv
// Tracks destinations in EX/MI/MR/WB, flags forwarding sources for the bypass unit,
// and stalls decode with a bubble into EX while a load result is still unavailable.
module seven_stage_hazard_tracker
    import seven_stage_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int COUNTER_WIDTH   = 32,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    seven_stage_hazard_tracker_if.slave hz,
    input  logic                     memory_stall,
    input  logic                     flush,
    input  logic                     scan,
    output logic [COUNTER_WIDTH-1:0] hazard_stall_count
);

    localparam int REC_W = rec_width(REG_ADDR_WIDTH);
    localparam logic [REC_W-1:0] BUBBLE = STAGE_BUBBLE[REC_W-1:0];

    logic [REC_W-1:0] ex_rec, mi_rec, mr_rec, wb_rec, decode_rec;
    logic [3:0]       rs1_hit, rs2_hit;
    logic             rs1_load, rs2_load, load_hazard;
    logic             running, flags_en;
    logic [31:0]      cycle_count;

    always_comb begin
        decode_rec                                  = BUBBLE;
        decode_rec[REC_VALID]                       = hz.decode_valid;
        decode_rec[REC_RD_LSB +: REG_ADDR_WIDTH]    = hz.decode_rd;
        decode_rec[REC_REGWRITE]                    = hz.decode_regwrite;
        decode_rec[REC_LOAD]                        = hz.decode_load;
    end

    seven_stage_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_rs1 (
        .src_used     (hz.decode_valid && hz.decode_rs1_used),
        .src          (hz.decode_rs1),
        .ex_rec       (ex_rec),
        .mi_rec       (mi_rec),
        .mr_rec       (mr_rec),
        .wb_rec       (wb_rec),
        .stage_hit    (rs1_hit),
        .load_pending (rs1_load)
    );

    seven_stage_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_rs2 (
        .src_used     (hz.decode_valid && hz.decode_rs2_used),
        .src          (hz.decode_rs2),
        .ex_rec       (ex_rec),
        .mi_rec       (mi_rec),
        .mr_rec       (mr_rec),
        .wb_rec       (wb_rec),
        .stage_hit    (rs2_hit),
        .load_pending (rs2_load)
    );

    assign load_hazard = rs1_load | rs2_load;
    // Outputs stay quiet through reset and the first cycle after release.
    assign flags_en    = running & ~load_hazard;

    assign hz.true_data_hazard          = running & load_hazard;
    assign hz.stall_decode              = running & ((load_hazard & ~flush) | memory_stall);
    assign hz.rs1_hazard_execute        = flags_en & rs1_hit[0];
    assign hz.rs1_hazard_memory_issue   = flags_en & rs1_hit[1];
    assign hz.rs1_hazard_memory_receive = flags_en & rs1_hit[2];
    assign hz.rs1_hazard_writeback      = flags_en & rs1_hit[3];
    assign hz.rs2_hazard_execute        = flags_en & rs2_hit[0];
    assign hz.rs2_hazard_memory_issue   = flags_en & rs2_hit[1];
    assign hz.rs2_hazard_memory_receive = flags_en & rs2_hit[2];
    assign hz.rs2_hazard_writeback      = flags_en & rs2_hit[3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_rec             <= BUBBLE;
            mi_rec             <= BUBBLE;
            mr_rec             <= BUBBLE;
            wb_rec             <= BUBBLE;
            hazard_stall_count <= '0;
            cycle_count        <= '0;
            running            <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage shifts from its neighbour's pre-edge value.
            running     <= 1'b1;
            cycle_count <= cycle_count + 1'b1;
            if (!memory_stall) begin
                mi_rec <= ex_rec;
                mr_rec <= mi_rec;
                wb_rec <= mr_rec;
                ex_rec <= (flush || load_hazard) ? BUBBLE : decode_rec;
                if (!flush && load_hazard && !(&hazard_stall_count))
                    hazard_stall_count <= hazard_stall_count + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && scan
            && (longint'(cycle_count) >= longint'(SCAN_CYCLES_MIN))
            && (longint'(cycle_count) <= longint'(SCAN_CYCLES_MAX)))
            $display("core %0d cycle %0d ex %h mi %h mr %h wb %h tdh %b stall %b rs1 %b%b%b%b rs2 %b%b%b%b count %0d",
                     CORE, cycle_count, ex_rec, mi_rec, mr_rec, wb_rec,
                     hz.true_data_hazard, hz.stall_decode,
                     hz.rs1_hazard_writeback, hz.rs1_hazard_memory_receive,
                     hz.rs1_hazard_memory_issue, hz.rs1_hazard_execute,
                     hz.rs2_hazard_writeback, hz.rs2_hazard_memory_receive,
                     hz.rs2_hazard_memory_issue, hz.rs2_hazard_execute,
                     hazard_stall_count);
    end
`endif

endmodule
